// File: rtl/borrow_select_sub8_pkg.sv
// Shared widths and stage-1 payload for the borrow-select subtractor.
// The payload holds both high-slice candidates so stage 2 only muxes.
package borrow_select_sub8_pkg;

    localparam int W_DEF   = 8;
    localparam int SLICE_W = W_DEF / 2;

    typedef struct packed {
        logic [SLICE_W-1:0] lo_d;
        logic               lo_b;
        logic [SLICE_W-1:0] hi_d0;
        logic               hi_b0;
        logic [SLICE_W-1:0] hi_d1;
        logic               hi_b1;
    } s1_payload_t;

    function automatic logic [SLICE_W:0] pick_high(input s1_payload_t p);
        return p.lo_b ? {p.hi_b1, p.hi_d1} : {p.hi_b0, p.hi_d0};
    endfunction

endpackage

// File: rtl/borrow_select_sub8_sub_slice.sv
// Ripple-borrow subtractor for one operand slice.
// diff = a - b - bin, bout set when the slice underflows.
module sub_slice
    import borrow_select_sub8_pkg::*;
#(
    parameter int N = SLICE_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign bout = br[N];

endmodule

// File: rtl/borrow_select_sub8.sv
// Two-stage borrow-select subtractor with valid/ready flow control.
// Stage 1 holds both high-slice candidates; stage 2 selects and presents.
module borrow_select_sub8
    import borrow_select_sub8_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         in_clk,
    input  logic         in_rst,
    input  logic         in_valid,
    output logic         out_ready,
    input  logic [W-1:0] in_A,
    input  logic [W-1:0] in_B,
    input  logic         in_Bin,
    output logic         out_valid,
    input  logic         in_ready,
    output logic [W-1:0] out_D,
    output logic         out_Bout
);

    localparam int H = W / 2;

    // The payload record is sized by the package slice width.
    if (W != W_DEF || (W % 2) != 0) begin : g_w_check
        $error("borrow_select_sub8: W must equal package W_DEF and be even");
    end

    logic [H-1:0] lo_d;
    logic         lo_b;
    logic [H-1:0] hi_d0;
    logic         hi_b0;
    logic [H-1:0] hi_d1;
    logic         hi_b1;

    sub_slice #(.N(H)) u_lo (
        .a    (in_A[H-1:0]),
        .b    (in_B[H-1:0]),
        .bin  (in_Bin),
        .diff (lo_d),
        .bout (lo_b)
    );

    sub_slice #(.N(H)) u_hi0 (
        .a    (in_A[W-1:H]),
        .b    (in_B[W-1:H]),
        .bin  (1'b0),
        .diff (hi_d0),
        .bout (hi_b0)
    );

    sub_slice #(.N(H)) u_hi1 (
        .a    (in_A[W-1:H]),
        .b    (in_B[W-1:H]),
        .bin  (1'b1),
        .diff (hi_d1),
        .bout (hi_b1)
    );

    s1_payload_t s1_next;
    s1_payload_t s1_q;
    logic        s1_valid;
    logic        ld2;
    logic        ld1;
    logic [H:0]  hi_sel;

    always_comb begin
        s1_next       = '0;
        s1_next.lo_d  = lo_d;
        s1_next.lo_b  = lo_b;
        s1_next.hi_d0 = hi_d0;
        s1_next.hi_b0 = hi_b0;
        s1_next.hi_d1 = hi_d1;
        s1_next.hi_b1 = hi_b1;
    end

    assign ld2       = !out_valid || in_ready;
    assign ld1       = !s1_valid || ld2;
    assign out_ready = ld1;
    assign hi_sel    = pick_high(s1_q);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            s1_valid <= 1'b0;
        end else if (ld1) begin
            s1_valid <= in_valid;
        end
    end

    // Payload needs no reset: it is only observed behind s1_valid.
    always_ff @(posedge in_clk) begin
        if (ld1 && in_valid) begin
            s1_q <= s1_next;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_valid <= 1'b0;
            out_D     <= '0;
            out_Bout  <= 1'b0;
        end else if (ld2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_D    <= {hi_sel[H-1:0], s1_q.lo_d};
                out_Bout <= hi_sel[H];
            end
        end
    end

endmodule

// File: tb/tb_borrow_select_sub8.sv
// Directed and scoreboarded checks for borrow_select_sub8.
// Inputs change 1ns after a rising edge; outputs are read 1ns later.
module tb_borrow_select_sub8;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_A;
    logic [7:0] in_B;
    logic       in_Bin;
    logic       out_valid;
    logic       in_ready;
    logic [7:0] out_D;
    logic       out_Bout;

    int n_vec  = 0;
    int n_fail = 0;

    borrow_select_sub8 #(.W(8)) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_Bin    (in_Bin),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_D     (out_D),
        .out_Bout  (out_Bout)
    );

    always #5 in_clk = ~in_clk;

    // {A, B, Bin, D, Bout}, expectations worked out by hand
    typedef logic [25:0] vec_t;

    vec_t dir_tab [9] = '{
        {8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
        {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1},
        {8'h01, 8'h01, 1'b0, 8'h00, 1'b0},
        {8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0},
        {8'h00, 8'hFF, 1'b0, 8'h01, 1'b1},
        {8'h00, 8'hFF, 1'b1, 8'h00, 1'b1},
        {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
        {8'h10, 8'h01, 1'b0, 8'h0F, 1'b0},
        {8'h3C, 8'h4D, 1'b1, 8'hEE, 1'b1}
    };

    vec_t b2b_tab [6] = '{
        {8'h12, 8'h34, 1'b0, 8'hDE, 1'b1},
        {8'h80, 8'h7F, 1'b0, 8'h01, 1'b0},
        {8'h80, 8'h7F, 1'b1, 8'h00, 1'b0},
        {8'h80, 8'h80, 1'b1, 8'hFF, 1'b1},
        {8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0},
        {8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1}
    };

    vec_t stl_tab [3] = '{
        {8'h20, 8'h10, 1'b0, 8'h10, 1'b0},
        {8'h0A, 8'h0B, 1'b0, 8'hFF, 1'b1},
        {8'h77, 8'h07, 1'b1, 8'h6F, 1'b0}
    };

    task automatic drive(input vec_t v, input logic vld);
        in_A     = v[25:18];
        in_B     = v[17:10];
        in_Bin   = v[9];
        in_valid = vld;
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic test_reset();
        in_rst   = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_A     = '0;
        in_B     = '0;
        in_Bin   = 1'b0;
        #3;
        n_vec++;
        if ({out_valid, out_D, out_Bout} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%b want 0/00/0",
                     out_valid, out_D, out_Bout);
        end
        repeat (2) tick();
        in_rst = 1'b0;
        #1;
        n_vec++;
        if (out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", out_ready);
        end
    endtask

    task automatic test_directed();
        in_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(dir_tab[i], 1'b1);
            tick();
            in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_latency: out_valid %b want 0 after 1 edge",
                         i, out_valid);
            end
            tick();
            n_vec++;
            if ({out_valid, out_D, out_Bout} !== {1'b1, dir_tab[i][8:0]}) begin
                n_fail++;
                $display("FAIL dir%0d: got v=%b d=%h b=%b want 1/%h/%b", i,
                         out_valid, out_D, out_Bout,
                         dir_tab[i][8:1], dir_tab[i][0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        in_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(b2b_tab[c], 1'b1);
            else       in_valid = 1'b0;
            #1;
            n_vec++;
            if (out_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready c%0d: got %b want 1", c, out_ready);
            end
            tick();
            n_vec++;
            if (c >= 1 && c <= 6) begin
                if ({out_valid, out_D, out_Bout} !== {1'b1, b2b_tab[c-1][8:0]}) begin
                    n_fail++;
                    $display("FAIL b2b_out c%0d: got v=%b d=%h b=%b want 1/%h/%b",
                             c, out_valid, out_D, out_Bout,
                             b2b_tab[c-1][8:1], b2b_tab[c-1][0]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle c%0d: out_valid %b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        in_ready = 1'b0;
        // two accepts with the consumer stalled
        for (int c = 0; c < 2; c++) begin
            drive(stl_tab[c], 1'b1);
            #1;
            n_vec++;
            if (out_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_accept c%0d: out_ready %b want 1", c, out_ready);
            end
            tick();
        end
        drive(stl_tab[2], 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if ({out_ready, out_valid, out_D, out_Bout} !==
                {2'b01, stl_tab[0][8:0]}) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got r=%b v=%b d=%h b=%b want 0/1/%h/%b",
                         c, out_ready, out_valid, out_D, out_Bout,
                         stl_tab[0][8:1], stl_tab[0][0]);
            end
            tick();
        end
        in_ready = 1'b1;
        #1;
        n_vec++;
        if (out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: out_ready %b want 1", out_ready);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({out_valid, out_D, out_Bout} !== {1'b1, stl_tab[k][8:0]}) begin
                n_fail++;
                $display("FAIL stall_drain%0d: got v=%b d=%h b=%b want 1/%h/%b",
                         k, out_valid, out_D, out_Bout,
                         stl_tab[k][8:1], stl_tab[k][0]);
            end
            tick();
            in_valid = 1'b0;
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_empty: out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_flight();
        in_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(b2b_tab[c], 1'b1);
            tick();
        end
        in_valid = 1'b0;
        #2;
        in_rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, out_D, out_Bout} !== 10'b0) begin
            n_fail++;
            $display("FAIL flight_reset: got v=%b d=%h b=%b want 0/00/0",
                     out_valid, out_D, out_Bout);
        end
        tick();
        in_rst   = 1'b0;
        in_ready = 1'b1;
        #1;
        n_vec++;
        if (out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flight_ready: got %b want 1", out_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flight_stale c%0d: out_valid %b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic [8:0] exp;
        logic [8:0] ref_v;
        int         sent = 0;
        int         cyc  = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            in_valid = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_ready = 1'($urandom_range(0, 3) != 0);
            in_A     = 8'($urandom);
            in_B     = 8'($urandom);
            in_Bin   = 1'($urandom);
            #1;
            if (out_valid && in_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got d=%h b=%b want no result",
                             out_D, out_Bout);
                end else begin
                    exp = q.pop_front();
                    if ({out_D, out_Bout} !== exp) begin
                        n_fail++;
                        $display("FAIL rand_data: got d=%h b=%b want %h/%b",
                                 out_D, out_Bout, exp[8:1], exp[0]);
                    end
                end
            end
            if (in_valid && out_ready) begin
                ref_v = {1'b0, in_A} - {1'b0, in_B} - {8'h00, in_Bin};
                q.push_back({ref_v[7:0], ref_v[8]});
                sent++;
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (q.size() != 0 || sent != 10000) begin
            n_fail++;
            $display("FAIL rand_drain: sent %0d pending %0d want 10000/0",
                     sent, q.size());
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
